// File: rtl/hack_io_pkg.sv
// ============================================================================
// Module   : hack_io_pkg
// Brief    : Shared types and constants for the memory-mapped SPI port (IO4).
// Revision : 1.0
// ============================================================================
`default_nettype none

package hack_io_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

    localparam int BUSY_BIT = 15;
    localparam int CSX_BIT  = 8;
    localparam int IO4_ADDR = 4100;
    localparam int BYTE_W   = 8;
    localparam int BITCNT_W = 3;

endpackage

`default_nettype wire

// File: rtl/spi_sck_gen.sv
// ============================================================================
// Module   : spi_sck_gen
// Brief    : SCK flop plus half-period tick; SPI_SCK_DIV4_EN doubles the
//            half-period with a 1-bit prescaler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_sck_gen (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);

    logic sck_q;
    logic sck_d;
    logic w_tick;

`ifdef SPI_SCK_DIV4_EN
    logic pre_q;
    logic pre_d;

    // Prescaler holds at 0 while idle so the first tick lands 2 clk after start
    always_comb begin
        pre_d = 1'b0;
        if (i_run) begin
            pre_d = ~pre_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign w_tick = i_run & pre_q;
`else
    assign w_tick = i_run;
`endif

    always_comb begin
        sck_d = sck_q;
        if (!i_run) begin
            sck_d = 1'b0;
        end else if (w_tick) begin
            sck_d = ~sck_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_q <= 1'b0;
        end else begin
            sck_q <= sck_d;
        end
    end

    assign o_sck  = sck_q;
    assign o_rise = w_tick & ~sck_q;
    assign o_fall = w_tick & sck_q;

endmodule

`default_nettype wire

// File: rtl/spi_ctrl.sv
// ============================================================================
// Module   : spi_ctrl
// Brief    : Mode-0 SPI byte master at IO4; SPI_SCK_DIV4_EN selects clk/4 SCK.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_ctrl
    import hack_io_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        CSX,
    output logic        SCK,
    output logic        SDO,
    input  logic        SDI
);

    spi_state_e          state_q, state_d;
    logic                csx_q, csx_d;
    logic                sdo_q, sdo_d;
    logic                sample_q, sample_d;
    logic [BYTE_W-1:0]   shreg_q, shreg_d;
    logic [BYTE_W-1:0]   rx_q, rx_d;
    logic [BITCNT_W-1:0] cnt_q, cnt_d;

    logic w_run;
    logic w_rise;
    logic w_fall;
    logic w_unused;

    assign w_run    = (state_q == SHIFT);
    assign w_unused = ^in[15:9];

    spi_sck_gen u_sck_gen (
        .clk    (clk),
        .reset  (reset),
        .i_run  (w_run),
        .o_sck  (SCK),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_comb begin
        state_d  = state_q;
        csx_d    = csx_q;
        sdo_d    = sdo_q;
        sample_d = sample_q;
        shreg_d  = shreg_q;
        rx_d     = rx_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    if (in[CSX_BIT]) begin
                        csx_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        csx_d   = 1'b0;
                        sdo_d   = in[7];
                        shreg_d = in[7:0];
                        cnt_d   = '0;
                    end
                end
            end

            SHIFT: begin
                if (w_rise) begin
                    sample_d = SDI;
                end
                if (w_fall) begin
                    shreg_d = {shreg_q[BYTE_W-2:0], sample_q};
                    if (cnt_q == 3'd7) begin
                        // Last falling edge: publish byte, park SDO, keep CSX low
                        state_d = IDLE;
                        rx_d    = {shreg_q[BYTE_W-2:0], sample_q};
                        sdo_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        sdo_d = shreg_q[BYTE_W-2];
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            csx_q    <= 1'b1;
            sdo_q    <= 1'b0;
            sample_q <= 1'b0;
            shreg_q  <= '0;
            rx_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            csx_q    <= csx_d;
            sdo_q    <= sdo_d;
            sample_q <= sample_d;
            shreg_q  <= shreg_d;
            rx_q     <= rx_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        out           = '0;
        out[BUSY_BIT] = w_run;
        out[7:0]      = rx_q;
    end

    assign CSX = csx_q;
    assign SDO = sdo_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_ctrl.sv
// ============================================================================
// Module   : tb_spi_ctrl
// Brief    : Randomized self-checking bench for spi_ctrl (honours SPI_SCK_DIV4_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_ctrl;

`ifdef SPI_SCK_DIV4_EN
    localparam int HALF = 2;
`else
    localparam int HALF = 1;
`endif
    localparam int BUSY_CYC = 16 * HALF;
    localparam int MAX_CYC  = 200;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        load     = 1'b0;
    logic [15:0] din      = 16'h0000;
    logic        sdi_drv  = 1'b0;
    logic        loopback = 1'b0;
    logic [15:0] dout;
    logic        csx;
    logic        sck;
    logic        sdo;
    logic        sdi;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] last_rx = 8'h00;

    assign sdi = loopback ? sdo : sdi_drv;

    always #20 clk = ~clk;

    spi_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .in    (din),
        .out   (dout),
        .CSX   (csx),
        .SCK   (sck),
        .SDO   (sdo),
        .SDI   (sdi)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode: 0 = random SDI, 1 = loopback, 2 = SDI held high.
    // Called at a falling clk edge; returns at the first falling edge with busy low.
    task automatic run_transfer(input logic [7:0] tx, input int mode, input bit inject);
        logic [7:0] sdo_bits = 8'h00;
        logic [7:0] rx_bits  = 8'h00;
        int  busy_cyc  = 0;
        int  rises     = 0;
        int  last_rise = -1;
        int  bad_gap   = 0;
        int  cyc       = 0;
        logic prev_sck = 1'b0;

        loopback = (mode == 1);
        sdi_drv  = (mode == 2) ? 1'b1 : 1'($urandom);
        load     = 1'b1;
        din      = {8'h00, tx};
        @(negedge clk);
        load = 1'b0;
        check_eq("start_busy", dout[15], 1'b1);
        check_eq("start_csx", csx, 1'b0);
        check_eq("start_sdo", sdo, tx[7]);

        while (dout[15] === 1'b1 && cyc < MAX_CYC) begin
            busy_cyc++;
            if (sck === 1'b1 && prev_sck === 1'b0) begin
                sdo_bits = {sdo_bits[6:0], sdo};
                rx_bits  = {rx_bits[6:0], sdi};
                if (last_rise >= 0 && (cyc - last_rise) != 2 * HALF) bad_gap++;
                last_rise = cyc;
                rises++;
            end
            prev_sck = sck;
            if (mode == 0) sdi_drv = 1'($urandom);
            if (inject && cyc == 2) begin
                load = 1'b1;
                din  = 16'h0055;
            end else begin
                load = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        load = 1'b0;

        check_eq("timeout", (cyc < MAX_CYC), 1'b1);
        check_eq("busy_len", busy_cyc, BUSY_CYC);
        check_eq("sck_rises", rises, 8);
        check_eq("sck_period", bad_gap, 0);
        check_eq("sdo_bits", sdo_bits, tx);
        check_eq("end_out", dout, {8'h00, rx_bits});
        check_eq("end_csx", csx, 1'b0);
        check_eq("end_sck", sck, 1'b0);
        check_eq("end_sdo", sdo, 1'b0);
        if (mode == 1) check_eq("loop_rx", dout[7:0], tx);
        if (mode == 2) check_eq("ones_rx", dout[7:0], 8'hFF);
        last_rx = rx_bits;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_csx", csx, 1'b1);
        check_eq("rst_sck", sck, 1'b0);
        check_eq("rst_sdo", sdo, 1'b0);
        check_eq("rst_out", dout, 16'h0000);
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_csx", csx, 1'b1);
        check_eq("post_rst_out", dout, 16'h0000);

        // Loopback of A5, then SDI held high while sending 3C
        run_transfer(8'hA5, 1, 1'b0);
        check_eq("a5_out", dout, 16'h00A5);
        run_transfer(8'h3C, 2, 1'b0);
        check_eq("3c_out", dout, 16'h00FF);

        // Write during SHIFT is ignored; only one transfer follows
        run_transfer(8'h12, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("no_second_xfer", dout[15], 1'b0);
            check_eq("no_second_csx", csx, 1'b0);
        end

        // Deassert chip select
        load = 1'b1;
        din  = 16'h0100;
        @(negedge clk);
        load = 1'b0;
        check_eq("deselect_csx", csx, 1'b1);
        check_eq("deselect_rx", dout[7:0], last_rx);
        check_eq("deselect_busy", dout[15], 1'b0);
        check_eq("deselect_sck", sck, 1'b0);
        @(negedge clk);
        check_eq("deselect_idle", dout[15], 1'b0);

        // Back-to-back random transfers, first one starting from CSX high
        for (int t = 0; t < 12; t++) begin
            run_transfer(8'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        // Reset mid-transfer at cycle 5
        loopback = 1'b1;
        load     = 1'b1;
        din      = 16'h005A;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("pre_abort_busy", dout[15], 1'b1);
        #5 reset = 1'b0;
        #1;
        check_eq("abort_csx", csx, 1'b1);
        check_eq("abort_out", dout, 16'h0000);
        check_eq("abort_sck", sck, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("release_busy", dout[15], 1'b0);
        check_eq("release_csx", csx, 1'b1);

        run_transfer(8'hC3, 1, 1'b0);
        check_eq("c3_out", dout, 16'h00C3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
